// File: rtl/store_queue_ctrl.sv
// Store-queue pointer and occupancy control.
// Tracks head (drain), commit pointer and tail (allocation) with explicit occupancy
// counts. Drains committed stores to the D-cache one per cycle. On a mispredict it
// discards speculative (uncommitted) stores.
module store_queue_ctrl #(
  parameter int unsigned SIZE_LSQ     = 32,
  parameter int unsigned SIZE_LSQ_LOG = 5,
  parameter int unsigned DISPATCH_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dispatchValid_i,
  input  logic [SIZE_LSQ_LOG-1:0] cntStNew_i,
  input  logic [1:0]              commitStCnt_i,
  input  logic                    recover_i,
  input  logic                    drainReady_i,
  output logic [SIZE_LSQ_LOG-1:0] stqHead_o,
  output logic [SIZE_LSQ_LOG-1:0] stqTail_o,
  output logic [SIZE_LSQ_LOG:0]   stqInsts_o,
  output logic [SIZE_LSQ_LOG:0]   stqCommitted_o,
  output logic                    stallDispatch_o,
  output logic                    drainValid_o,
  output logic [SIZE_LSQ_LOG-1:0] drainIndex_o
);

  localparam int unsigned PW = SIZE_LSQ_LOG;
  localparam int unsigned CW = SIZE_LSQ_LOG + 1;
  // Stall once a full bundle might not fit.
  localparam logic [CW-1:0] StallThresh = CW'(SIZE_LSQ - DISPATCH_W);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [CW-1:0] insts_q, insts_d;
  logic [CW-1:0] committed_q, committed_d;

  logic          stall;
  logic          drain_valid;
  logic          disp_fire;
  logic          drain_fire;
  logic [CW-1:0] disp_n;
  logic [CW-1:0] cm_n;
  logic [CW-1:0] dr_n;

  assign stall       = (insts_q > StallThresh);
  assign drain_valid = (committed_q != '0);
  assign disp_fire   = dispatchValid_i & ~stall & ~recover_i;
  assign drain_fire  = drain_valid & drainReady_i;
  assign disp_n      = disp_fire ? CW'(cntStNew_i) : '0;
  assign cm_n        = CW'(commitStCnt_i);
  assign dr_n        = CW'(drain_fire);

  // Next pointer/count state; recovery rewinds tail to the (updated) commit pointer.
  always_comb begin
    head_d       = head_q + PW'(dr_n);
    commit_ptr_d = commit_ptr_q + PW'(cm_n);
    committed_d  = committed_q + cm_n - dr_n;
    tail_d       = tail_q + PW'(disp_n);
    insts_d      = insts_q + disp_n - dr_n;
    if (recover_i) begin
      tail_d  = commit_ptr_q + PW'(cm_n);
      insts_d = committed_q + cm_n - dr_n;
    end
  end

  // State registers with synchronous reset that discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      commit_ptr_q <= '0;
      insts_q      <= '0;
      committed_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      commit_ptr_q <= commit_ptr_d;
      insts_q      <= insts_d;
      committed_q  <= committed_d;
    end
  end

  assign stqHead_o       = head_q;
  assign stqTail_o       = tail_q;
  assign stqInsts_o      = insts_q;
  assign stqCommitted_o  = committed_q;
  assign stallDispatch_o = stall;
  assign drainValid_o    = drain_valid;
  assign drainIndex_o    = head_q;

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Randomized bench for store_queue_ctrl against an entry-list reference model.
module tb_store_queue_ctrl;

  localparam int SIZE = 32;
  localparam int LOGN = 5;
  localparam int DW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            dispatch_valid;
  logic [LOGN-1:0] cnt_st_new;
  logic [1:0]      commit_cnt;
  logic            recover;
  logic            drain_ready;
  logic [LOGN-1:0] head, tail, drain_index;
  logic [LOGN:0]   insts, committed;
  logic            stall, drain_valid;

  store_queue_ctrl #(
    .SIZE_LSQ    (SIZE),
    .SIZE_LSQ_LOG(LOGN),
    .DISPATCH_W  (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dispatchValid_i(dispatch_valid),
    .cntStNew_i     (cnt_st_new),
    .commitStCnt_i  (commit_cnt),
    .recover_i      (recover),
    .drainReady_i   (drain_ready),
    .stqHead_o      (head),
    .stqTail_o      (tail),
    .stqInsts_o     (insts),
    .stqCommitted_o (committed),
    .stallDispatch_o(stall),
    .drainValid_o   (drain_valid),
    .drainIndex_o   (drain_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: live entries oldest-first, 1 = committed; plus absolute head index.
  bit q[$];
  int m_head;
  int hits_full, hits_wrap, hits_recover, hits_stall_held;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int n_committed();
    int c = 0;
    foreach (q[i]) if (q[i]) c++;
    return c;
  endfunction

  task automatic check_all();
    int sz = q.size();
    int nc = n_committed();
    check_eq("head", int'(head), m_head);
    check_eq("tail", int'(tail), (m_head + sz) % SIZE);
    check_eq("insts", int'(insts), sz);
    check_eq("committed", int'(committed), nc);
    check_eq("stall", int'(stall), (sz > SIZE - DW) ? 1 : 0);
    check_eq("drain_valid", int'(drain_valid), (nc != 0) ? 1 : 0);
    check_eq("drain_index", int'(drain_index), m_head);
  endtask

  // Apply one cycle of inputs to the model (state after the coming rising edge).
  task automatic model_step(input bit rst, input bit dv, input int cnt, input int cm,
                            input bit rec, input bit rdy);
    int sz = q.size();
    int nc = n_committed();
    bit full_stall = (sz > SIZE - DW);
    if (rst) begin
      q.delete();
      m_head = 0;
      return;
    end
    if (cm > sz - nc) begin
      n_err++;
      $display("FAIL commit_precondition: got %0d expected <= %0d", cm, sz - nc);
      cm = 0;
    end
    for (int i = 0; i < cm; i++) q[nc + i] = 1'b1;
    if (nc != 0 && rdy) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % SIZE;
    end
    if (rec) begin
      while (q.size() > 0 && q[q.size() - 1] == 1'b0) void'(q.pop_back());
      hits_recover++;
    end else if (dv && !full_stall) begin
      if (m_head + sz + cnt >= SIZE && m_head + sz < SIZE) hits_wrap++;
      for (int i = 0; i < cnt; i++) q.push_back(1'b0);
      if (q.size() == SIZE) hits_full++;
    end else if (dv && full_stall) begin
      hits_stall_held++;
    end
  endtask

  initial begin
    int phase, sz, nc, cmax, cm, cnt;
    bit rst, dv, rec, rdy;
    m_head = 0;
    hits_full = 0; hits_wrap = 0; hits_recover = 0; hits_stall_held = 0;
    reset = 1'b1; dispatch_valid = 1'b0; cnt_st_new = '0; commit_cnt = '0;
    recover = 1'b0; drain_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all();  // reset state
    for (int cyc = 0; cyc < 6000; cyc++) begin
      sz    = q.size();
      nc    = n_committed();
      phase = (cyc / 150) % 4;
      rst   = ($urandom_range(0, 499) == 0);
      cnt   = $urandom_range(0, DW);
      case (phase)
        0: begin  // fill: little draining or committing
          dv = ($urandom_range(0, 9) < 9); rdy = ($urandom_range(0, 9) == 0);
          rec = ($urandom_range(0, 99) == 0);
        end
        1: begin  // commit-heavy, drain stalled often
          dv = ($urandom_range(0, 1) == 1); rdy = ($urandom_range(0, 3) == 0);
          rec = ($urandom_range(0, 39) == 0);
        end
        2: begin  // drain-heavy
          dv = ($urandom_range(0, 2) == 0); rdy = ($urandom_range(0, 9) < 9);
          rec = ($urandom_range(0, 19) == 0);
        end
        default: begin
          dv = $urandom_range(0, 1) == 1; rdy = $urandom_range(0, 1) == 1;
          rec = ($urandom_range(0, 14) == 0);
        end
      endcase
      cmax = sz - nc;
      if (cmax > 2) cmax = 2;
      if (phase == 0) cm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cmax) : 0;
      else cm = $urandom_range(0, cmax);
      reset          = rst;
      dispatch_valid = dv;
      cnt_st_new     = LOGN'(cnt);
      commit_cnt     = 2'(cm);
      recover        = rec;
      drain_ready    = rdy;
      model_step(rst, dv, cnt, cm, rec, rdy);
      @(negedge clk);
      check_all();
    end
    reset = 1'b0; dispatch_valid = 1'b0; commit_cnt = '0; recover = 1'b0;
    $display("coverage: full=%0d wrap=%0d recover=%0d stall_held=%0d",
             hits_full, hits_wrap, hits_recover, hits_stall_held);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
